// File: rtl/pwm_from_regs.sv
// PWM generator fed by device registers; config is double-buffered into shadows that
// reload only at a period boundary, so a register write never glitches a running period.
module pwm_from_regs #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_en,
    input  logic               cfg_pol,
    input  logic [WIDTH-1:0]   cfg_period,
    input  logic [WIDTH-1:0]   cfg_duty,
    input  logic [PRESC_W-1:0] cfg_presc,
    input  logic               cfg_update,
    output logic               pwm_out,
    output logic               period_tick,
    output logic               upd_pending
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     cnt_q, cnt_d;
    logic [PRESC_W-1:0]   presc_cnt_q, presc_cnt_d;
    logic [WIDTH-1:0]     period_sh_q, period_sh_d;
    logic [WIDTH-1:0]     duty_sh_q, duty_sh_d;
    logic [PRESC_W-1:0]   presc_sh_q, presc_sh_d;
    logic                 pol_sh_q, pol_sh_d;
    logic                 pwm_q, pwm_d;
    logic                 tick_q, tick_d;
    logic                 upd_q, upd_d;

    logic presc_tick;
    logic wrap;
    logic load;

    assign presc_tick = (presc_cnt_q == presc_sh_q);
    assign wrap       = presc_tick && (cnt_q == period_sh_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        presc_cnt_d = presc_cnt_q;
        pwm_d       = pwm_q;
        tick_d      = 1'b0;
        upd_d       = upd_q;
        load        = 1'b0;

        case (state_q)
            StIdle: begin
                pwm_d = cfg_pol;
                upd_d = 1'b0;
                if (cfg_en) begin
                    load        = 1'b1;
                    cnt_d       = '0;
                    presc_cnt_d = '0;
                    state_d     = StRun;
                end
            end
            StRun: begin
                if (!cfg_en) begin
                    state_d     = StIdle;
                    cnt_d       = '0;
                    presc_cnt_d = '0;
                    upd_d       = 1'b0;
                    pwm_d       = pol_sh_q;
                end else begin
                    // Unsigned compare: duty 0 never active, duty > period always active.
                    pwm_d  = (cnt_q < duty_sh_q) ^ pol_sh_q;
                    tick_d = wrap;
                    if (presc_tick) begin
                        presc_cnt_d = '0;
                        cnt_d       = wrap ? '0 : cnt_q + WIDTH'(1);
                    end else begin
                        presc_cnt_d = presc_cnt_q + PRESC_W'(1);
                    end
                    if (wrap && (upd_q || cfg_update)) begin
                        load  = 1'b1;
                        upd_d = 1'b0;
                    end else if (cfg_update) begin
                        upd_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        period_sh_d = load ? cfg_period : period_sh_q;
        duty_sh_d   = load ? cfg_duty   : duty_sh_q;
        presc_sh_d  = load ? cfg_presc  : presc_sh_q;
        pol_sh_d    = load ? cfg_pol    : pol_sh_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            presc_cnt_q <= '0;
            period_sh_q <= '0;
            duty_sh_q   <= '0;
            presc_sh_q  <= '0;
            pol_sh_q    <= 1'b0;
            pwm_q       <= 1'b0;
            tick_q      <= 1'b0;
            upd_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            presc_cnt_q <= presc_cnt_d;
            period_sh_q <= period_sh_d;
            duty_sh_q   <= duty_sh_d;
            presc_sh_q  <= presc_sh_d;
            pol_sh_q    <= pol_sh_d;
            pwm_q       <= pwm_d;
            tick_q      <= tick_d;
            upd_q       <= upd_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign period_tick = tick_q;
    assign upd_pending = upd_q;

endmodule

// File: tb/tb_pwm_from_regs.sv
// Directed self-checking bench for pwm_from_regs: waveforms, shadow reload, disable, reset.
module tb_pwm_from_regs;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_en;
    logic       cfg_pol;
    logic [7:0] cfg_period;
    logic [7:0] cfg_duty;
    logic [7:0] cfg_presc;
    logic       cfg_update;
    logic       pwm_out;
    logic       period_tick;
    logic       upd_pending;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pwm_from_regs #(.WIDTH(8), .PRESC_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_en     (cfg_en),
        .cfg_pol    (cfg_pol),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .cfg_presc  (cfg_presc),
        .cfg_update (cfg_update),
        .pwm_out    (pwm_out),
        .period_tick(period_tick),
        .upd_pending(upd_pending)
    );

    // Samples are taken 1 time unit after the edge; inputs change at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bit i holds the sample taken i+1 clocks after the enabling edge.
    task automatic capture(input int n, output logic [63:0] pw, output logic [63:0] tk);
        pw = '0;
        tk = '0;
        for (int i = 0; i < n; i++) begin
            step();
            pw[i] = pwm_out;
            tk[i] = period_tick;
        end
    endtask

    // Reference waveform for a fresh period started from cnt=0 with fixed shadows.
    function automatic void build_exp(input int n, input int p, input int per, input int d,
                                      input logic pol, output logic [63:0] pw,
                                      output logic [63:0] tk);
        int c;
        pw = '0;
        tk = '0;
        for (int i = 0; i < n; i++) begin
            c     = (i / (p + 1)) % (per + 1);
            pw[i] = (c < d) ^ pol;
            tk[i] = (((i + 1) % ((p + 1) * (per + 1))) == 0);
        end
    endfunction

    task automatic restart(input logic pol, input int per, input int d, input int p);
        cfg_en     = 1'b0;
        cfg_update = 1'b0;
        step();
        step();
        cfg_pol    = pol;
        cfg_period = 8'(per);
        cfg_duty   = 8'(d);
        cfg_presc  = 8'(p);
        cfg_en     = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        cfg_en     = 1'b0;
        cfg_pol    = 1'b0;
        cfg_period = 8'd0;
        cfg_duty   = 8'd0;
        cfg_presc  = 8'd0;
        cfg_update = 1'b0;
        step();
        step();
        checks++;
        if ({pwm_out, period_tick, upd_pending} !== 3'b000) begin
            errors++;
            $display("FAIL reset_state: got pwm/tick/upd=%b required 000",
                     {pwm_out, period_tick, upd_pending});
        end
        rst        = 1'b0;
        cfg_update = 1'b1;
        step();
        cfg_update = 1'b0;
        checks++;
        if (upd_pending !== 1'b0) begin
            errors++;
            $display("FAIL idle_update_ignored: got upd_pending=%b required 0", upd_pending);
        end
    endtask

    task automatic test_waveform(input string name, input int per, input int d, input int p,
                                 input int n);
        logic [63:0] pw, tk, epw, etk;
        restart(1'b0, per, d, p);
        checks++;
        if (pwm_out !== 1'b0) begin
            errors++;
            $display("FAIL %s_enable_level: got pwm=%b required 0", name, pwm_out);
        end
        capture(n, pw, tk);
        build_exp(n, p, per, d, 1'b0, epw, etk);
        checks++;
        if (pw !== epw) begin
            errors++;
            $display("FAIL %s_pwm: got %h required %h", name, pw, epw);
        end
        checks++;
        if (tk !== etk) begin
            errors++;
            $display("FAIL %s_tick: got %h required %h", name, tk, etk);
        end
    endtask

    task automatic test_update();
        logic [63:0] pw, tk;
        restart(1'b0, 9, 3, 0);
        pw = '0;
        tk = '0;
        for (int i = 0; i < 20; i++) begin
            step();
            pw[i] = pwm_out;
            tk[i] = period_tick;
            if (i == 3) begin
                cfg_duty   = 8'd5;
                cfg_update = 1'b1;
            end
            if (i == 4) begin
                cfg_update = 1'b0;
                checks++;
                if (upd_pending !== 1'b1) begin
                    errors++;
                    $display("FAIL upd_set: got upd_pending=%b required 1", upd_pending);
                end
            end
            if (i == 8) begin
                checks++;
                if (upd_pending !== 1'b1) begin
                    errors++;
                    $display("FAIL upd_held: got upd_pending=%b required 1", upd_pending);
                end
            end
            if (i == 9) begin
                checks++;
                if (upd_pending !== 1'b0) begin
                    errors++;
                    $display("FAIL upd_clear: got upd_pending=%b required 0", upd_pending);
                end
            end
        end
        // 3 high, 7 low, then 5 high, 5 low.
        checks++;
        if (pw[19:0] !== 20'h07C07) begin
            errors++;
            $display("FAIL update_pwm: got %h required 07c07", pw[19:0]);
        end
        checks++;
        if (tk[19:0] !== 20'h80200) begin
            errors++;
            $display("FAIL update_tick: got %h required 80200", tk[19:0]);
        end
    endtask

    task automatic test_pol_disable();
        logic [63:0] pw, tk;
        logic        bad;
        restart(1'b0, 9, 3, 0);
        pw = '0;
        tk = '0;
        for (int i = 0; i < 21; i++) begin
            step();
            pw[i] = pwm_out;
            tk[i] = period_tick;
            if (i == 8) begin
                cfg_pol    = 1'b1;
                cfg_update = 1'b1;
            end
            if (i == 9) begin
                cfg_update = 1'b0;
                checks++;
                if (upd_pending !== 1'b0) begin
                    errors++;
                    $display("FAIL wrap_update_no_pending: got upd_pending=%b required 0",
                             upd_pending);
                end
            end
        end
        checks++;
        if (pw[20:0] !== 21'h0FE007) begin
            errors++;
            $display("FAIL pol_pwm: got %h required 0fe007", pw[20:0]);
        end
        checks++;
        if (tk[20:0] !== 21'h080200) begin
            errors++;
            $display("FAIL pol_tick: got %h required 080200", tk[20:0]);
        end
        cfg_en = 1'b0;
        step();
        checks++;
        if ({pwm_out, period_tick} !== 2'b10) begin
            errors++;
            $display("FAIL disable_level: got pwm/tick=%b required 10", {pwm_out, period_tick});
        end
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (pwm_out !== 1'b1 || period_tick !== 1'b0 || upd_pending !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL disabled_quiet: got deviation=%b required 0", bad);
        end
    endtask

    task automatic test_reset_mid_period();
        logic [63:0] pw, tk, epw, etk;
        restart(1'b0, 9, 3, 0);
        step();
        cfg_update = 1'b1;
        step();
        cfg_update = 1'b0;
        checks++;
        if (upd_pending !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_pending: got upd_pending=%b required 1", upd_pending);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({pwm_out, period_tick, upd_pending} !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset_state: got pwm/tick/upd=%b required 000",
                     {pwm_out, period_tick, upd_pending});
        end
        step();
        capture(20, pw, tk);
        build_exp(20, 0, 9, 3, 1'b0, epw, etk);
        checks++;
        if (pw !== epw) begin
            errors++;
            $display("FAIL post_reset_pwm: got %h required %h", pw, epw);
        end
        checks++;
        if (tk !== etk) begin
            errors++;
            $display("FAIL post_reset_tick: got %h required %h", tk, etk);
        end
    endtask

    initial begin
        test_reset();
        test_waveform("basic", 9, 3, 0, 30);
        test_waveform("presc", 9, 3, 1, 60);
        test_waveform("duty0", 9, 0, 0, 30);
        test_waveform("duty_full", 9, 12, 0, 30);
        test_update();
        test_pol_disable();
        test_reset_mid_period();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
